// File: rtl/mouse_analog_emu_if.sv
// mouse_analog_emu_if
//   Bundles the signals between hps_io, the mouse emulator and the 5200 core
//   player-1 stick inputs.
//   slave  : used by mouse_analog_emu (takes the mouse, stick and control inputs,
//            drives the stick values to the core)
//   master : used by the environment driving the emulator
//   Signals:
//     ps2_mouse   [24:0] hps_io mouse packet ([24] toggle strobe, [5]/[4] Y/X sign,
//                        [23:16] dY, [15:8] dX, [1:0] R/L button)
//     joya        [15:0] physical analog stick {Y, X}, signed
//     joy_in      [20:0] physical digital joystick bits
//     cpu_halt           CPU halted by the ZPU (OSD/loader active)
//     invert_y           subtract the Y delta instead of adding it
//     recentre_en        enable idle auto-recentre
//     ax, ay      [7:0]  stick X/Y presented to the core
//     joy_out     [20:0] digital joystick bits presented to the core
//     emu_active         mouse emulation currently owns the stick
interface mouse_analog_emu_if;
    logic [24:0] ps2_mouse;
    logic [15:0] joya;
    logic [20:0] joy_in;
    logic        cpu_halt;
    logic        invert_y;
    logic        recentre_en;
    logic [7:0]  ax;
    logic [7:0]  ay;
    logic [20:0] joy_out;
    logic        emu_active;

    modport slave (
        input  ps2_mouse, joya, joy_in, cpu_halt, invert_y, recentre_en,
        output ax, ay, joy_out, emu_active
    );

    modport master (
        output ps2_mouse, joya, joy_in, cpu_halt, invert_y, recentre_en,
        input  ax, ay, joy_out, emu_active
    );
endinterface

// File: rtl/mouse_analog_emu.sv
// mouse_analog_emu
//   Turns PS/2 mouse packets into an emulated 5200 analog stick for player 1.
//   Mouse motion (halved, clamped to +/-DELTA_MAX per packet) is accumulated into
//   a saturating signed 8-bit X/Y position. After IDLE_TICKS quiet cycles the
//   position walks back to centre one LSB per DECAY_PERIOD cycles (when enabled).
//   Mouse L/R buttons replace fire bits [5:4] while emulating. Any physical
//   analog-stick deflection or a CPU halt hands the stick back to the real one.
//   Ports:
//     clk_sys  system clock
//     reset    asynchronous, active-high reset
//     bus      mouse_analog_emu_if.slave (see interface header)
module mouse_analog_emu #(
    parameter int unsigned DELTA_MAX    = 10,
    parameter int unsigned IDLE_TICKS   = 2**22,
    parameter int unsigned DECAY_PERIOD = 2**16
) (
    input logic                  clk_sys,
    input logic                  reset,
    mouse_analog_emu_if.slave    bus
);

    localparam int unsigned IW = (IDLE_TICKS   > 1) ? $clog2(IDLE_TICKS)   : 1;
    localparam int unsigned DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TICKS - 1);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_PERIOD - 1);
    localparam logic signed [8:0] DMAX = 9'(DELTA_MAX);
    localparam logic signed [8:0] DMIN = -DMAX;

    typedef enum logic {IDLE_WAIT, DECAY} state_t;

    state_t             state;
    logic               emu;
    logic               armed;
    logic               old_stb;
    logic signed [7:0]  mx, my;
    logic [IW-1:0]      idle_cnt;
    logic [DW-1:0]      decay_cnt;

    logic               pkt;
    logic               release_stick;
    logic signed [8:0]  dx, dy, dxc, dyc, nx, ny;
    logic               unused_bits;

    function automatic logic signed [8:0] clamp_delta(input logic signed [8:0] d);
        if (d > DMAX)
            return DMAX;
        else if (d < DMIN)
            return DMIN;
        return d;
    endfunction

    function automatic logic signed [7:0] sat8(input logic signed [8:0] v);
        if (v > 9'sd127)
            return 8'sh7F;
        else if (v < -9'sd128)
            return 8'sh80;
        return v[7:0];
    endfunction

    function automatic logic signed [7:0] toward_zero(input logic signed [7:0] v);
        if (v > 8'sd0)
            return v - 8'sd1;
        else if (v < 8'sd0)
            return v + 8'sd1;
        return v;
    endfunction

    // The first cycle after reset only captures the strobe level, so a strobe
    // that was already high during reset is not mistaken for a new packet.
    assign pkt           = armed & (old_stb != bus.ps2_mouse[24]);
    assign release_stick = (bus.joya != '0) | bus.cpu_halt;

    always_comb begin
        // Sign-extended and halved deltas: {sign, sign, byte[7:1]}.
        dx  = {bus.ps2_mouse[4], bus.ps2_mouse[4], bus.ps2_mouse[15:9]};
        dy  = {bus.ps2_mouse[5], bus.ps2_mouse[5], bus.ps2_mouse[23:17]};
        dxc = clamp_delta(dx);
        dyc = clamp_delta(dy);
        nx  = {mx[7], mx} + dxc;
        ny  = bus.invert_y ? ({my[7], my} - dyc) : ({my[7], my} + dyc);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE_WAIT;
            emu       <= 1'b0;
            armed     <= 1'b0;
            old_stb   <= 1'b0;
            mx        <= '0;
            my        <= '0;
            idle_cnt  <= '0;
            decay_cnt <= '0;
        end else begin
            old_stb <= bus.ps2_mouse[24];
            armed   <= 1'b1;
            if (release_stick) begin
                state     <= IDLE_WAIT;
                emu       <= 1'b0;
                mx        <= '0;
                my        <= '0;
                idle_cnt  <= '0;
                decay_cnt <= '0;
            end else if (pkt) begin
                state     <= IDLE_WAIT;
                emu       <= 1'b1;
                mx        <= sat8(nx);
                my        <= sat8(ny);
                idle_cnt  <= '0;
                decay_cnt <= '0;
            end else if (emu && bus.recentre_en) begin
                case (state)
                    IDLE_WAIT: begin
                        // Leaving on the last count doubles as the saturation.
                        if (idle_cnt == IDLE_LAST)
                            state <= DECAY;
                        else
                            idle_cnt <= idle_cnt + 1'b1;
                    end
                    DECAY: begin
                        // Once centred the counter freezes; nothing left to do.
                        if (mx != 8'sd0 || my != 8'sd0) begin
                            if (decay_cnt == DECAY_LAST) begin
                                decay_cnt <= '0;
                                mx        <= toward_zero(mx);
                                my        <= toward_zero(my);
                            end else begin
                                decay_cnt <= decay_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE_WAIT;
                endcase
            end else begin
                state     <= IDLE_WAIT;
                idle_cnt  <= '0;
                decay_cnt <= '0;
            end
        end
    end

    assign bus.emu_active = emu;
    assign bus.ax         = emu ? mx : bus.joya[7:0];
    assign bus.ay         = emu ? my : bus.joya[15:8];
    assign bus.joy_out    = emu ? {bus.joy_in[20:6], bus.ps2_mouse[1:0], bus.joy_in[3:0]}
                                : bus.joy_in;

    // Packet fields the stick does not use (dX/dY LSBs, middle button, overflow).
    assign unused_bits = ^{bus.ps2_mouse[16], bus.ps2_mouse[8], bus.ps2_mouse[7:6],
                           bus.ps2_mouse[3:2]};

endmodule
